// File: rtl/scan_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl_if
// Brief    : Operand / product valid-ready bundle for scan_chain_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface scan_chain_ctrl_if #(
    parameter int A_W = 4,
    parameter int B_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [A_W-1:0]       a;
    logic [B_W-1:0]       b;
    logic                 out_valid;
    logic                 out_ready;
    logic [A_W+B_W-1:0]   product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl
// Brief    : Shifts operands into a scan-chain multiplier, captures once, and
//            shifts the product back out. SCAN_CTRL_CHECK_EN adds a result check.
// Revision : 1.0  initial release
// ============================================================================
module scan_chain_ctrl #(
    parameter int A_W = 4,
    parameter int B_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    scan_chain_ctrl_if.slave  bus,
    output logic              busy,
    output logic              err,
    output logic              chain_rst_n,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out
);
    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(P_W) + 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(P_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT_OUT = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [P_W-1:0]   r_sr;
    logic [P_W-1:0]   r_res;
    logic [P_W-1:0]   r_product;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_scan_en;
    logic             r_scan_in;
    logic             r_chain_rst_n;

    logic [P_W-1:0]   w_ab;
    logic [P_W-1:0]   w_res_next;
    logic             w_accept;
    logic             w_last_sample;

    assign w_ab          = {bus.a, bus.b};
    assign w_res_next    = {scan_out, r_res[P_W-1:1]};
    assign w_accept      = (r_state == IDLE) && bus.in_valid && r_in_ready;
    assign w_last_sample = (r_state == SHIFT_OUT) && (r_cnt == c_cnt_last);

    // Outputs are registered, so each transition loads the value the next
    // state presents; scan_in leads sr by one bit for the same reason.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sr          <= '0;
            r_res         <= '0;
            r_product     <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_scan_en     <= 1'b1;
            r_scan_in     <= 1'b0;
            r_chain_rst_n <= 1'b0;
        end else begin
            r_chain_rst_n <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= SHIFT_IN;
                        r_cnt      <= '0;
                        r_sr       <= {1'b0, w_ab[P_W-1:1]};
                        r_scan_in  <= w_ab[0];
                        r_scan_en  <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SHIFT_IN: begin
                    if (r_cnt == c_cnt_last) begin
                        r_state   <= CAPTURE;
                        r_cnt     <= '0;
                        r_scan_en <= 1'b0;
                        r_scan_in <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt + CNT_W'(1);
                        r_scan_in <= r_sr[0];
                        r_sr      <= {1'b0, r_sr[P_W-1:1]};
                    end
                end
                CAPTURE: begin
                    r_state   <= SHIFT_OUT;
                    r_cnt     <= '0;
                    r_scan_en <= 1'b1;
                end
                SHIFT_OUT: begin
                    r_res <= w_res_next;
                    if (w_last_sample) begin
                        r_state     <= DONE;
                        r_cnt       <= '0;
                        r_product   <= w_res_next;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCAN_CTRL_CHECK_EN
    logic [P_W-1:0] r_expected;
    logic           r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_expected <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_expected <= P_W'(bus.a) * P_W'(bus.b);
            end
            if (w_last_sample) begin
                r_err <= (w_res_next != r_expected);
            end else if ((r_state == DONE) && bus.out_ready) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;
    assign busy          = r_busy;
    assign chain_rst_n   = r_chain_rst_n;
    assign scan_en       = r_scan_en;
    assign scan_in       = r_scan_in;
endmodule
`default_nettype wire
